// File: rtl/mdu_seq_ctrl_if.sv
// Request/response bundle between the pipeline and the multiply/divide sequencer.
// The master drives the request; the slave (sequencer) returns status and HI/LO.
interface mdu_seq_ctrl_if #(
    parameter int WIDTH = 32
) ();
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             busy_o;
    logic             done_o;
    logic             dz_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, src1_i, src2_i,
        input  busy_o, done_o, dz_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, src1_i, src2_i,
        output busy_o, done_o, dz_o, hi_o, lo_o
    );
endinterface

// File: rtl/mdu_seq_ctrl.sv
// Iterative MULT/MULTU (and DIV/DIVU) sequencer with HI/LO result registers.
// Define MDU_DIV_EN to compile in the restoring divider and divide-by-zero flag.
module mdu_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mdu_seq_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
`ifdef MDU_DIV_EN
    localparam int AW = WIDTH + 2;
`else
    localparam int AW = WIDTH + 1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic               fin_r;
    logic               busy_r;
    logic               done_r;
    logic               dz_r;
    logic               neg_p_r;
    logic [WIDTH-1:0]   opb_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [2*WIDTH-1:0] acc_r;
`ifdef MDU_DIV_EN
    logic               is_div_r;
    logic               neg_r_r;
    logic [WIDTH-1:0]   src1_r;
`endif

    logic               s1_s;
    logic               s2_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [AW-1:0]      add_a_s;
    logic [AW-1:0]      add_b_s;
    logic [AW-1:0]      add_res_s;
    logic [2*WIDTH-1:0] acc_step_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;
    logic               res_dz_s;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        logic [WIDTH-1:0] r;
        if (neg) begin
            r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
        logic [2*WIDTH-1:0] r;
        if (neg) begin
            r = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Operand magnitudes and signs captured at accept (signed ops only).
    always_comb begin
        s1_s    = bus.op_i[0] & bus.src1_i[WIDTH-1];
        s2_s    = bus.op_i[0] & bus.src2_i[WIDTH-1];
        a_mag_s = cond_neg(bus.src1_i, s1_s);
        b_mag_s = cond_neg(bus.src2_i, s2_s);
    end

    // One iteration step on the shared adder/subtractor.
    always_comb begin
        add_b_s    = {{(AW-WIDTH){1'b0}}, opb_r};
        add_a_s    = {{(AW-WIDTH){1'b0}}, acc_r[2*WIDTH-1:WIDTH]};
        add_res_s  = add_a_s + add_b_s;
        acc_step_s = {1'b0, acc_r[2*WIDTH-1:1]};
`ifdef MDU_DIV_EN
        if (is_div_r) begin
            // Trial subtract of the divisor from {remainder, next dividend bit}.
            add_a_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH-1]};
            add_res_s = add_a_s - add_b_s;
            if (add_res_s[WIDTH+1]) begin
                acc_step_s = {acc_r[2*WIDTH-2:0], 1'b0};
            end else begin
                acc_step_s = {add_res_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end
        end else begin
`endif
            acc_step_s = acc_r[0] ? {add_res_s[WIDTH:0], acc_r[WIDTH-1:1]}
                                  : {1'b0, acc_r[2*WIDTH-1:1]};
`ifdef MDU_DIV_EN
        end
`endif
    end

    // Sign fix-up of the finished magnitude result into HI/LO form.
    always_comb begin
        prod_s   = cond_neg2(acc_r, neg_p_r);
        res_hi_s = prod_s[2*WIDTH-1:WIDTH];
        res_lo_s = prod_s[WIDTH-1:0];
        res_dz_s = 1'b0;
`ifdef MDU_DIV_EN
        if (is_div_r) begin
            if (opb_r == '0) begin
                res_hi_s = src1_r;
                res_lo_s = {WIDTH{1'b1}};
                res_dz_s = 1'b1;
            end else begin
                res_hi_s = cond_neg(acc_r[2*WIDTH-1:WIDTH], neg_r_r);
                res_lo_s = cond_neg(acc_r[WIDTH-1:0], neg_p_r);
                res_dz_s = 1'b0;
            end
        end else begin
            res_dz_s = 1'b0;
        end
`endif
    end

    // Control FSM, iteration registers and HI/LO result registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            fin_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dz_r     <= 1'b0;
            neg_p_r  <= 1'b0;
            opb_r    <= '0;
            acc_r    <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
`ifdef MDU_DIV_EN
            is_div_r <= 1'b0;
            neg_r_r  <= 1'b0;
            src1_r   <= '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start_i) begin
                        busy_r  <= 1'b1;
                        dz_r    <= 1'b0;
                        cnt_r   <= '0;
                        fin_r   <= 1'b0;
                        opb_r   <= b_mag_s;
                        acc_r   <= {{WIDTH{1'b0}}, a_mag_s};
                        neg_p_r <= s1_s ^ s2_s;
`ifdef MDU_DIV_EN
                        is_div_r <= bus.op_i[1];
                        neg_r_r  <= s1_s;
                        src1_r   <= bus.src1_i;
                        state_r  <= ST_CALC;
`else
                        // Divide not built: finish at once and flag the op as unsupported.
                        if (bus.op_i[1]) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            dz_r    <= 1'b1;
                        end else begin
                            state_r <= ST_CALC;
                        end
`endif
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_CALC: begin
                    // WIDTH iterations, then one fix-up cycle that commits HI/LO.
                    if (!fin_r) begin
                        acc_r <= acc_step_s;
                        if (cnt_r == CNT_LAST) begin
                            fin_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end else begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        hi_r    <= res_hi_s;
                        lo_r    <= res_lo_s;
                        dz_r    <= res_dz_s;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o = busy_r;
    assign bus.done_o = done_r;
    assign bus.dz_o   = dz_r;
    assign bus.hi_o   = hi_r;
    assign bus.lo_o   = lo_r;
endmodule
